// File: rtl/led_pkg.sv
// Shared types for the LED/display datapath: count type, saturation limit and meter FSM states.
package led_pkg;
    typedef logic [7:0] count_t;

    localparam count_t COUNT_MAX = 8'd255;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GATE = 1'b1
    } fsm_state_t;

    // Saturating increment; returns {attempted_past_max, result}.
    function automatic logic [8:0] sat_inc(input count_t a, input logic inc);
        if (inc && (a == COUNT_MAX)) begin
            return {1'b1, COUNT_MAX};
        end
        return {1'b0, a + count_t'(inc)};
    endfunction
endpackage

// File: rtl/pulse_edge_detect.sv
// Rising-edge detector, optional two-flop synchronizer when FRAME_RATE_METER_SYNC_EN is defined.
// Latency: event_o in the cycle the rise is sampled; two cycles later when synchronized.
// Backpressure: none; emits a one-cycle event per rising edge.
module pulse_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pulse_i,
    output logic event_o
);
    logic sample;
    logic prev_q;

`ifdef FRAME_RATE_METER_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pulse_i;
            sync2_q <= sync1_q;
        end
    end

    assign sample = sync2_q;
`else
    assign sample = pulse_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sample;
        end
    end

    assign event_o = sample & ~prev_q;
endmodule

// File: rtl/frame_rate_meter.sv
// Frame-rate meter: counts frame_done_in rising edges over a CLK_FREQ-cycle gate; FRAME_RATE_METER_SYNC_EN adds input sync.
// Latency: result registered at the edge closing the terminal gate cycle (+2 cycles input delay when synchronized).
// Backpressure: none; count_valid_out is a fire-and-forget one-cycle strobe.
module frame_rate_meter
    import led_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       enable_in,
    input  logic       frame_done_in,
    output logic [7:0] count_out,
    output logic       count_valid_out,
    output logic       overflow_out
);
    localparam int            GW        = $clog2(CLK_FREQ);
    localparam logic [GW-1:0] GATE_LAST = GW'(CLK_FREQ - 1);

    fsm_state_t    state_q, state_d;
    logic [GW-1:0] gate_q, gate_d;
    count_t        acc_q, acc_d, acc_inc;
    count_t        count_q, count_d;
    logic          sat_q, sat_d, inc_sat;
    logic          ovf_q, ovf_d;
    logic          vld_q, vld_d;
    logic          evt;

    pulse_edge_detect u_edge (
        .clk_i   (clk_in),
        .rst_i   (rst_in),
        .pulse_i (frame_done_in),
        .event_o (evt)
    );

    assign {inc_sat, acc_inc} = sat_inc(acc_q, evt);

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        vld_d   = 1'b0;
        case (state_q)
            IDLE: begin
                gate_d = '0;
                acc_d  = '0;
                sat_d  = 1'b0;
                if (enable_in) begin
                    state_d = GATE;
                end
            end
            GATE: begin
                if (!enable_in) begin
                    // Partial window is dropped; published results stay put.
                    state_d = IDLE;
                    gate_d  = '0;
                    acc_d   = '0;
                    sat_d   = 1'b0;
                end else if (gate_q == GATE_LAST) begin
                    count_d = acc_inc;
                    ovf_d   = sat_q | inc_sat;
                    vld_d   = 1'b1;
                    gate_d  = '0;
                    acc_d   = '0;
                    sat_d   = 1'b0;
                end else begin
                    gate_d = gate_q + GW'(1);
                    acc_d  = acc_inc;
                    sat_d  = sat_q | inc_sat;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            gate_q  <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
        end
    end

    assign count_out       = count_q;
    assign count_valid_out = vld_q;
    assign overflow_out    = ovf_q;
endmodule

// File: tb/tb_frame_rate_meter.sv
// Bench for frame_rate_meter: a 100-cycle gate instance and a 1000-cycle gate instance for saturation.
module tb_frame_rate_meter;
`ifdef FRAME_RATE_METER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst [2];
    logic       en  [2];
    logic       fd  [2];
    logic [7:0] cnt [2];
    logic       vld [2];
    logic       ovf [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    frame_rate_meter #(.CLK_FREQ(100)) dut0 (
        .clk_in(clk), .rst_in(rst[0]), .enable_in(en[0]), .frame_done_in(fd[0]),
        .count_out(cnt[0]), .count_valid_out(vld[0]), .overflow_out(ovf[0])
    );
    frame_rate_meter #(.CLK_FREQ(1000)) dut1 (
        .clk_in(clk), .rst_in(rst[1]), .enable_in(en[1]), .frame_done_in(fd[1]),
        .count_out(cnt[1]), .count_valid_out(vld[1]), .overflow_out(ovf[1])
    );

    function automatic int fq(input int g);
        return (g != 0) ? 1000 : 100;
    endfunction

    // n single-cycle pulses starting at window offset off, one every two cycles.
    function automatic logic pat(input int i, input int n, input int off);
        return (i >= off) && (i < off + 2 * n) && (((i - off) % 2) == 0);
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: per window, count rising edges of the (optionally delayed) input as an unbounded integer.
    for (genvar g = 0; g < 2; g++) begin : mdl
        localparam int FG = (g != 0) ? 1000 : 100;
        int         pos = 0;
        int         n = 0;
        bit         in_gate = 1'b0;
        bit         prev = 1'b0;
        bit         eff;
        bit         rise;
        bit         pipe[$];
        logic [7:0] m_cnt = 8'd0;
        bit         m_ovf = 1'b0;
        bit         m_vld = 1'b0;

        always @(posedge clk or posedge rst[g]) begin
            if (rst[g]) begin
                pipe.delete();
                prev = 1'b0; in_gate = 1'b0; pos = 0; n = 0;
                m_cnt = 8'd0; m_ovf = 1'b0; m_vld = 1'b0;
            end else begin
                pipe.push_back(fd[g]);
                eff = 1'b0;
                if (pipe.size() > LAT) eff = pipe.pop_front();
                rise = eff && !prev;
                prev = eff;
                m_vld = 1'b0;
                if (!in_gate) begin
                    if (en[g]) begin in_gate = 1'b1; pos = 0; n = 0; end
                end else if (!en[g]) begin
                    in_gate = 1'b0;
                end else begin
                    n += int'(rise);
                    if (pos == FG - 1) begin
                        m_cnt = (n > 255) ? 8'd255 : 8'(n);
                        m_ovf = (n > 255);
                        m_vld = 1'b1;
                        pos = 0;
                        n = 0;
                    end else begin
                        pos++;
                    end
                end
            end
        end

        always @(posedge clk) begin
            #1;
            tests++;
            if (cnt[g] !== m_cnt || ovf[g] !== m_ovf || vld[g] !== m_vld) begin
                fails++;
                $display("FAIL sb%0d t=%0t: cnt/ovf/vld got %0d/%0d/%0d, expected %0d/%0d/%0d",
                         g, $time, cnt[g], ovf[g], vld[g], m_cnt, m_ovf, m_vld);
            end
        end
    end

    task automatic wait_strobe(input int g, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vld[g] && n < budget);
        if (!vld[g]) check($sformatf("strobe_timeout%0d", g), 0, 1);
    endtask

    task automatic align(input int g);
        int n;
        en[1 - g] = 1'b0;
        fd[0] = 1'b0;
        fd[1] = 1'b0;
        en[g] = 1'b1;
        wait_strobe(g, fq(g) + 10, n);
    endtask

    // Starts at the first negedge of a window, ends at the first negedge of the next one.
    task automatic run_window(input int g, input int n, input int off, input string nm,
                              input int ecnt, input int eovf);
        for (int i = 0; i < fq(g); i++) begin
            fd[g] = pat(i, n, off);
            @(negedge clk);
        end
        fd[g] = 1'b0;
        check({nm, "_vld"}, int'(vld[g]), 1);
        check({nm, "_cnt"}, int'(cnt[g]), ecnt);
        check({nm, "_ovf"}, int'(ovf[g]), eovf);
    endtask

    typedef struct {
        int g;
        int n;
        int off;
        int ecnt;
        int eovf;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int  n;
        bit  bad;

        tbl[0] = '{0, 7, 5, 7, 0};
        tbl[1] = '{0, 0, 5, 0, 0};
        tbl[2] = '{0, 1, 40, 1, 0};
        tbl[3] = '{0, 45, 3, 45, 0};
        tbl[4] = '{1, 500 - LAT / 2, 0, 255, 1};
        tbl[5] = '{1, 3, 10, 3, 0};
        tbl[6] = '{1, 255, 2, 255, 0};
        tbl[7] = '{1, 256, 2, 255, 1};
        tbl[8] = '{1, 0, 0, 0, 0};

        rst[0] = 1'b1; rst[1] = 1'b1;
        en[0]  = 1'b1; en[1]  = 1'b0;
        fd[0]  = 1'b0; fd[1]  = 1'b0;

        // Reset with enable high; GATE starts on the first edge after release.
        repeat (3) @(negedge clk);
        check("rst_cnt", int'(cnt[0]), 0);
        check("rst_vld", int'(vld[0]), 0);
        check("rst_ovf", int'(ovf[0]), 0);
        rst[0] = 1'b0; rst[1] = 1'b0;
        wait_strobe(0, 300, n);
        check("rst_first_strobe_after_gate_entry", n - 1, 100);
        check("rst_first_cnt", int'(cnt[0]), 0);

        for (int i = 0; i < 9; i++) begin
            if (i == 0 || tbl[i].g != tbl[i - 1].g) align(tbl[i].g);
            run_window(tbl[i].g, tbl[i].n, tbl[i].off, $sformatf("vec%0d", i),
                       tbl[i].ecnt, tbl[i].eovf);
        end

        // Edge in the terminal cycle, then held high for 300 more cycles.
        align(0);
        repeat (99) @(negedge clk);
        fd[0] = 1'b1;
        @(negedge clk);
        check("term_vld", int'(vld[0]), 1);
        check("term_cnt", int'(cnt[0]), (LAT == 0) ? 1 : 0);
        for (int w = 0; w < 3; w++) begin
            repeat (100) @(negedge clk);
            check($sformatf("hold%0d_vld", w), int'(vld[0]), 1);
            check($sformatf("hold%0d_cnt", w), int'(cnt[0]), (w == 0 && LAT != 0) ? 1 : 0);
        end
        fd[0] = 1'b0;
        run_window(0, 0, 5, "after_hold", 0, 0);

        // Enable drop at cycle 50 after 4 edges, then re-enable.
        run_window(0, 3, 5, "pre_drop", 3, 0);
        for (int i = 0; i < 50; i++) begin
            fd[0] = pat(i, 4, 5);
            @(negedge clk);
        end
        fd[0] = 1'b0;
        en[0] = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (vld[0] || cnt[0] != 8'd3) bad = 1'b1;
        end
        check("drop_no_strobe_hold", int'(bad), 0);
        check("drop_cnt", int'(cnt[0]), 3);
        en[0] = 1'b1;
        @(negedge clk);
        run_window(0, 2, 5, "reenter", 2, 0);

        // Reset at cycle 60 with 5 edges accumulated.
        for (int i = 0; i < 60; i++) begin
            fd[0] = pat(i, 5, 5);
            @(negedge clk);
        end
        fd[0] = 1'b0;
        rst[0] = 1'b1;
        #1;
        check("midrst_cnt", int'(cnt[0]), 0);
        check("midrst_vld", int'(vld[0]), 0);
        check("midrst_ovf", int'(ovf[0]), 0);
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        wait_strobe(0, 300, n);
        check("midrst_next_strobe_after_gate_entry", n - 1, 100);
        check("midrst_next_cnt", int'(cnt[0]), 0);

        // Random traffic on both instances against the reference.
        en[0] = 1'b1; en[1] = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                rst[g] = ($urandom_range(0, 1499) == 0);
                if (en[g]) begin
                    if ($urandom_range(0, 599) == 0) en[g] = 1'b0;
                end else if ($urandom_range(0, 19) == 0) begin
                    en[g] = 1'b1;
                end
            end
            if ($urandom_range(0, 7) == 0) fd[0] = ~fd[0];
            if ($urandom_range(0, 4) != 0) fd[1] = ~fd[1];
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
